// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the fetch/data memory arbiter.
// Widths match the DECODER bus constants.
package mem_arbiter_pkg;

    localparam int unsigned ADR_W = 20;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and external memory bus grouped for mem_arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic             freq;
    logic [ADR_W-1:0] fadr;
    logic             fack;
    logic [DAT_W-1:0] fdtr;
    logic             sigflush;

    logic             dreq;
    logic             dwe;
    logic [ADR_W-1:0] dadr;
    logic [DAT_W-1:0] dwdata;
    logic             dack;
    logic [DAT_W-1:0] drdata;

    logic             mreq;
    logic             mwe;
    logic [ADR_W-1:0] madr;
    logic [DAT_W-1:0] mdto;
    logic             mack;
    logic [DAT_W-1:0] mdti;

    modport master (
        input  freq, fadr, sigflush, dreq, dwe, dadr, dwdata, mack, mdti,
        output fack, fdtr, dack, drdata, mreq, mwe, madr, mdto
    );

    modport slave (
        output freq, fadr, sigflush, dreq, dwe, dadr, dwdata, mack, mdti,
        input  fack, fdtr, dack, drdata, mreq, mwe, madr, mdto
    );

endinterface

// File: rtl/mem_arbiter_fair_cnt.sv
// arb_fair_cnt: counts data grants made while a fetch waits and flags when
// the run limit is reached. Instantiated only under ARB_FAIRNESS_EN.
module arb_fair_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_idle,
    input  logic freq,
    input  logic fetch_grant,
    input  logic data_grant,
    output logic at_limit
);

    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_DATA_RUN);

    logic [RUN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_grant || (in_idle && !freq)) begin
            cnt_d = '0;
        end else if (data_grant && freq) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == RUN_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch vs load/store on one bus.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while a fetch waits.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_bad_run
        $error("MAX_DATA_RUN out of range 1..15");
    end

    arb_state_e       state_q, state_d;
    logic             mreq_q, mreq_d;
    logic             mwe_q, mwe_d;
    logic             fack_q, fack_d;
    logic             dack_q, dack_d;
    logic [ADR_W-1:0] madr_q, madr_d;
    logic [DAT_W-1:0] mdto_q, mdto_d;
    logic [DAT_W-1:0] fdtr_q, fdtr_d;
    logic [DAT_W-1:0] drdata_q, drdata_d;

    logic fetch_ok;
    logic fetch_pri;
    logic fetch_grant;
    logic data_grant;

    assign fetch_ok = bus.freq && !bus.sigflush;

`ifdef ARB_FAIRNESS_EN
    arb_fair_cnt #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_fair_cnt (
        .clk        (clk),
        .rst        (rst),
        .in_idle    (state_q == ARB_IDLE),
        .freq       (bus.freq),
        .fetch_grant(fetch_grant),
        .data_grant (data_grant),
        .at_limit   (fetch_pri)
    );
`else
    assign fetch_pri = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mreq_d      = mreq_q;
        mwe_d       = mwe_q;
        madr_d      = madr_q;
        mdto_d      = mdto_q;
        fdtr_d      = fdtr_q;
        drdata_d    = drdata_q;
        fack_d      = 1'b0;
        dack_d      = 1'b0;
        fetch_grant = 1'b0;
        data_grant  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (fetch_ok && fetch_pri) begin
                    fetch_grant = 1'b1;
                end else if (bus.dreq) begin
                    data_grant = 1'b1;
                end else if (fetch_ok) begin
                    fetch_grant = 1'b1;
                end
            end
            ARB_FETCH: begin
                // A flush racing the completion just drops the data.
                if (bus.mack) begin
                    mreq_d  = 1'b0;
                    state_d = ARB_IDLE;
                    if (!bus.sigflush) begin
                        fack_d = 1'b1;
                        fdtr_d = bus.mdti;
                    end
                end else if (bus.sigflush) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (bus.mack) begin
                    mreq_d  = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (bus.mack) begin
                    mreq_d  = 1'b0;
                    dack_d  = 1'b1;
                    state_d = ARB_IDLE;
                    if (!mwe_q) begin
                        drdata_d = bus.mdti;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (fetch_grant) begin
            state_d = ARB_FETCH;
            mreq_d  = 1'b1;
            mwe_d   = 1'b0;
            madr_d  = bus.fadr;
            mdto_d  = '0;
        end
        if (data_grant) begin
            state_d = ARB_DATA;
            mreq_d  = 1'b1;
            mwe_d   = bus.dwe;
            madr_d  = bus.dadr;
            mdto_d  = bus.dwdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            madr_q   <= '0;
            mdto_q   <= '0;
            fack_q   <= 1'b0;
            dack_q   <= 1'b0;
            fdtr_q   <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            madr_q   <= madr_d;
            mdto_q   <= mdto_d;
            fack_q   <= fack_d;
            dack_q   <= dack_d;
            fdtr_q   <= fdtr_d;
            drdata_q <= drdata_d;
        end
    end

    assign bus.mreq   = mreq_q;
    assign bus.mwe    = mwe_q;
    assign bus.madr   = madr_q;
    assign bus.mdto   = mdto_q;
    assign bus.fack   = fack_q;
    assign bus.dack   = dack_q;
    assign bus.fdtr   = fdtr_q;
    assign bus.drdata = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-vector bench for mem_arbiter, plus fairness and reset sequences.
// Expected grant order follows ARB_FAIRNESS_EN when it is defined.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_DATA_RUN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        freq;
        logic [19:0] fadr;
        logic        flush;
        logic        dreq;
        logic        dwe;
        logic [19:0] dadr;
        logic [15:0] dwdata;
        logic        mack;
        logic [15:0] mdti;
        logic        e_mreq;
        logic        e_mwe;
        logic [19:0] e_madr;
        logic [15:0] e_mdto;
        logic        e_fack;
        logic        e_dack;
        logic [15:0] e_fdtr;
        logic [15:0] e_drdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic freq, input logic [19:0] fadr, input logic flush,
        input logic dreq, input logic dwe, input logic [19:0] dadr, input logic [15:0] dwdata,
        input logic mack, input logic [15:0] mdti,
        input logic e_mreq, input logic e_mwe, input logic [19:0] e_madr, input logic [15:0] e_mdto,
        input logic e_fack, input logic e_dack, input logic [15:0] e_fdtr, input logic [15:0] e_drdata);
        vec_t v;
        v.freq = freq; v.fadr = fadr; v.flush = flush;
        v.dreq = dreq; v.dwe = dwe; v.dadr = dadr; v.dwdata = dwdata;
        v.mack = mack; v.mdti = mdti;
        v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_madr = e_madr; v.e_mdto = e_mdto;
        v.e_fack = e_fack; v.e_dack = e_dack; v.e_fdtr = e_fdtr; v.e_drdata = e_drdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.freq     = v.freq;
        bus.fadr     = v.fadr;
        bus.sigflush = v.flush;
        bus.dreq     = v.dreq;
        bus.dwe      = v.dwe;
        bus.dadr     = v.dadr;
        bus.dwdata   = v.dwdata;
        bus.mack     = v.mack;
        bus.mdti     = v.mdti;
    endtask

    task automatic compare(input int idx, input vec_t v);
        check($sformatf("v%0d mreq", idx),   32'(bus.mreq),   32'(v.e_mreq));
        check($sformatf("v%0d mwe", idx),    32'(bus.mwe),    32'(v.e_mwe));
        check($sformatf("v%0d madr", idx),   32'(bus.madr),   32'(v.e_madr));
        check($sformatf("v%0d mdto", idx),   32'(bus.mdto),   32'(v.e_mdto));
        check($sformatf("v%0d fack", idx),   32'(bus.fack),   32'(v.e_fack));
        check($sformatf("v%0d dack", idx),   32'(bus.dack),   32'(v.e_dack));
        check($sformatf("v%0d fdtr", idx),   32'(bus.fdtr),   32'(v.e_fdtr));
        check($sformatf("v%0d drdata", idx), 32'(bus.drdata), 32'(v.e_drdata));
    endtask

    initial begin
        string exp_order;
        byte   got_order[10];
        int    ngrant;
        logic  prev_mreq;

        // freq fadr fl | dreq dwe dadr dwdata | mack mdti || mreq mwe madr mdto fack dack fdtr drdata
        vq.push_back(mk(1, 20'hA2C1, 0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'hA2C1, 16'h0,    0, 0, 16'h0,    16'h0));
        vq.push_back(mk(1, 20'hA2C1, 0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'hA2C1, 16'h0,    0, 0, 16'h0,    16'h0));
        vq.push_back(mk(1, 20'hA2C1, 0, 0, 0, 20'h0,     16'h0,    1, 16'h1234, 0, 0, 20'hA2C1, 16'h0,    1, 0, 16'h1234, 16'h0));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'hA2C1, 16'h0,    0, 0, 16'h1234, 16'h0));
        vq.push_back(mk(1, 20'h200,  0, 1, 1, 20'h10,    16'hBEEF, 0, 16'h0,    1, 1, 20'h10,   16'hBEEF, 0, 0, 16'h1234, 16'h0));
        vq.push_back(mk(1, 20'h200,  0, 1, 1, 20'h10,    16'hBEEF, 1, 16'h5555, 0, 1, 20'h10,   16'hBEEF, 0, 1, 16'h1234, 16'h0));
        vq.push_back(mk(1, 20'h200,  0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h200,  16'h0,    0, 0, 16'h1234, 16'h0));
        vq.push_back(mk(1, 20'h200,  0, 0, 0, 20'h0,     16'h0,    1, 16'hCAFE, 0, 0, 20'h200,  16'h0,    1, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'h200,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h300,  0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h300,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h300,  1, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h300,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h100,  0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h300,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h100,  0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h300,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h100,  0, 0, 0, 20'h0,     16'h0,    1, 16'h9999, 0, 0, 20'h300,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h100,  0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h100,  16'h0,    0, 0, 16'hCAFE, 16'h0));
        vq.push_back(mk(1, 20'h100,  0, 0, 0, 20'h0,     16'h0,    1, 16'h0ABC, 0, 0, 20'h100,  16'h0,    1, 0, 16'h0ABC, 16'h0));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'h100,  16'h0,    0, 0, 16'h0ABC, 16'h0));
        vq.push_back(mk(1, 20'h400,  0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    1, 0, 20'h400,  16'h0,    0, 0, 16'h0ABC, 16'h0));
        vq.push_back(mk(1, 20'h400,  1, 0, 0, 20'h0,     16'h0,    1, 16'h7777, 0, 0, 20'h400,  16'h0,    0, 0, 16'h0ABC, 16'h0));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'h400,  16'h0,    0, 0, 16'h0ABC, 16'h0));
        vq.push_back(mk(0, 20'h0,    0, 1, 0, 20'h20,    16'h1111, 0, 16'h0,    1, 0, 20'h20,   16'h1111, 0, 0, 16'h0ABC, 16'h0));
        vq.push_back(mk(0, 20'h0,    0, 1, 0, 20'h20,    16'h1111, 1, 16'h5A5A, 0, 0, 20'h20,   16'h1111, 0, 1, 16'h0ABC, 16'h5A5A));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    1, 16'hFFFF, 0, 0, 20'h20,   16'h1111, 0, 0, 16'h0ABC, 16'h5A5A));
        vq.push_back(mk(0, 20'h0,    0, 1, 0, 20'h30,    16'h0,    0, 16'h0,    1, 0, 20'h30,   16'h0,    0, 0, 16'h0ABC, 16'h5A5A));
        vq.push_back(mk(0, 20'h0,    1, 1, 0, 20'h30,    16'h0,    0, 16'h0,    1, 0, 20'h30,   16'h0,    0, 0, 16'h0ABC, 16'h5A5A));
        vq.push_back(mk(0, 20'h0,    0, 1, 0, 20'h30,    16'h0,    1, 16'h1357, 0, 0, 20'h30,   16'h0,    0, 1, 16'h0ABC, 16'h1357));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'h30,   16'h0,    0, 0, 16'h0ABC, 16'h1357));
        vq.push_back(mk(1, 20'h500,  1, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'h30,   16'h0,    0, 0, 16'h0ABC, 16'h1357));
        vq.push_back(mk(0, 20'h0,    0, 0, 0, 20'h0,     16'h0,    0, 16'h0,    0, 0, 20'h30,   16'h0,    0, 0, 16'h0ABC, 16'h1357));

        // Reset state
        rst = 1'b1;
        drive(mk(0, 20'h0, 0, 0, 0, 20'h0, 16'h0, 0, 16'h0, 0, 0, 20'h0, 16'h0, 0, 0, 16'h0, 16'h0));
        repeat (2) @(negedge clk);
        compare(-1, mk(0, 20'h0, 0, 0, 0, 20'h0, 16'h0, 0, 16'h0, 0, 0, 20'h0, 16'h0, 0, 0, 16'h0, 16'h0));
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge clk);
            compare(i, vq[i]);
        end

        // Both ports held high against zero-wait memory
`ifdef ARB_FAIRNESS_EN
        exp_order = "DDDDFDDDDF";
`else
        exp_order = "DDDDDDDDDD";
`endif
        bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dadr = 20'h40; bus.dwdata = 16'h0;
        bus.freq = 1'b1; bus.fadr = 20'h50; bus.sigflush = 1'b0;
        bus.mack = 1'b0; bus.mdti = 16'h0F0F;
        ngrant = 0;
        prev_mreq = 1'b0;
        for (int cyc = 0; cyc < 100 && ngrant < 10; cyc++) begin
            @(negedge clk);
            if (bus.mreq && !prev_mreq) begin
                got_order[ngrant] = (bus.madr == 20'h50) ? "F" : "D";
                ngrant++;
            end
            prev_mreq = bus.mreq;
            bus.mack = bus.mreq;
        end
        bus.dreq = 1'b0;
        bus.freq = 1'b0;
        if (ngrant < 10) begin
            check("grant_budget", 32'(ngrant), 32'd10);
        end
        for (int k = 0; k < ngrant; k++) begin
            check($sformatf("grant%0d", k), 32'(got_order[k]), 32'(exp_order[k]));
        end
        repeat (3) begin
            @(negedge clk);
            bus.mack = bus.mreq;
        end
        check("quiet_mreq", 32'(bus.mreq), 32'd0);

        // Reset in the middle of a data transfer
        bus.mack = 1'b0;
        bus.dreq = 1'b1; bus.dwe = 1'b1; bus.dadr = 20'h60; bus.dwdata = 16'h4242;
        @(negedge clk);
        check("rst_pre_mreq", 32'(bus.mreq), 32'd1);
        check("rst_pre_madr", 32'(bus.madr), 32'h60);
        #2 rst = 1'b1;
        #1;
        check("rst_mreq", 32'(bus.mreq), 32'd0);
        check("rst_dack", 32'(bus.dack), 32'd0);
        check("rst_madr", 32'(bus.madr), 32'd0);
        check("rst_fdtr", 32'(bus.fdtr), 32'd0);
        check("rst_drdata", 32'(bus.drdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("regrant_mreq", 32'(bus.mreq), 32'd1);
        check("regrant_mwe", 32'(bus.mwe), 32'd1);
        check("regrant_madr", 32'(bus.madr), 32'h60);
        check("regrant_mdto", 32'(bus.mdto), 32'h4242);
        bus.mack = 1'b1;
        @(negedge clk);
        check("regrant_dack", 32'(bus.dack), 32'd1);
        check("regrant_mreq_off", 32'(bus.mreq), 32'd0);
        bus.dreq = 1'b0;
        bus.mack = 1'b0;
        @(negedge clk);
        check("regrant_dack_off", 32'(bus.dack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
